// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter that shares one dispense motor between NUM_SLOTS slot requesters,
// with per-slot stock counting, motor timeout fault, and optional VEND_LOW_STOCK_EN flags.
module vend_dispense_arbiter #(
    parameter int NUM_SLOTS     = 4,
    parameter int STOCK_MAX     = 8,
    parameter int MOTOR_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef VEND_LOW_STOCK_EN
    output logic [NUM_SLOTS-1:0]         low_stock,
`endif
    input  logic [NUM_SLOTS-1:0]         req,
    output logic [NUM_SLOTS-1:0]         ack,
    output logic                         ack_ok,
    output logic                         ack_empty,
    output logic                         ack_fault,
    output logic                         motor_start,
    output logic [$clog2(NUM_SLOTS)-1:0] motor_sel,
    input  logic                         motor_done,
    input  logic                         restock,
    input  logic [$clog2(NUM_SLOTS)-1:0] restock_slot,
    output logic                         fault,
    input  logic                         fault_clr,
    output logic                         busy
);

    localparam int SEL_W   = $clog2(NUM_SLOTS);
    localparam int IDX_W   = SEL_W + 1;
    localparam int STOCK_W = $clog2(STOCK_MAX + 1);
    localparam int TIMER_W = $clog2(MOTOR_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, FAULT} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     motor_sel_q, motor_sel_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [STOCK_W-1:0]   stock_q [NUM_SLOTS];
    logic [STOCK_W-1:0]   stock_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] ack_q, ack_d;
    logic                 ack_ok_q, ack_ok_d;
    logic                 ack_empty_q, ack_empty_d;
    logic                 ack_fault_q, ack_fault_d;
    logic                 motor_start_q, motor_start_d;
    logic                 fault_q, fault_d;
    logic                 busy_q, busy_d;

    logic [SEL_W-1:0]     winner;
    logic                 found;
    logic [IDX_W-1:0]     idx_w;
    logic [SEL_W-1:0]     rr_next;

    // Scan from rr_ptr upward, wrapping, and take the first asserted request.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx_w = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx_w >= IDX_W'(NUM_SLOTS)) begin
                idx_w = idx_w - IDX_W'(NUM_SLOTS);
            end
            if (!found && req[idx_w[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_w[SEL_W-1:0];
            end
        end
    end

    assign rr_next = (motor_sel_q == SEL_W'(NUM_SLOTS - 1)) ? '0 : motor_sel_q + SEL_W'(1);

    always_comb begin
        state_d       = state_q;
        motor_sel_d   = motor_sel_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        stock_d       = stock_q;
        ack_d         = '0;
        ack_ok_d      = 1'b0;
        ack_empty_d   = 1'b0;
        ack_fault_d   = 1'b0;
        motor_start_d = 1'b0;
        fault_d       = fault_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    motor_sel_d = winner;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (stock_q[motor_sel_q] == '0) begin
                    ack_d[motor_sel_q] = 1'b1;
                    ack_empty_d        = 1'b1;
                    rr_ptr_d           = rr_next;
                    state_d            = IDLE;
                end else begin
                    motor_start_d = 1'b1;
                    timer_d       = '0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // A done pulse on the expiry edge still counts as a successful dispense.
                if (motor_done) begin
                    if (stock_q[motor_sel_q] != '0) begin
                        stock_d[motor_sel_q] = stock_q[motor_sel_q] - STOCK_W'(1);
                    end
                    ack_d[motor_sel_q] = 1'b1;
                    ack_ok_d           = 1'b1;
                    rr_ptr_d           = rr_next;
                    state_d            = IDLE;
                end else if (timer_q == TIMER_W'(MOTOR_TIMEOUT - 1)) begin
                    ack_d[motor_sel_q] = 1'b1;
                    ack_fault_d        = 1'b1;
                    fault_d            = 1'b1;
                    rr_ptr_d           = rr_next;
                    state_d            = FAULT;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restock is applied last so it overrides a same-edge decrement.
        if (restock && (int'(restock_slot) < NUM_SLOTS)) begin
            stock_d[restock_slot] = STOCK_W'(STOCK_MAX);
        end

        busy_d = (state_d != IDLE);
    end

`ifdef VEND_LOW_STOCK_EN
    logic [NUM_SLOTS-1:0] low_stock_q, low_stock_d;

    always_comb begin
        low_stock_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            low_stock_d[i] = (stock_q[i] <= STOCK_W'(1));
        end
    end

    assign low_stock = low_stock_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            motor_sel_q   <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            ack_q         <= '0;
            ack_ok_q      <= 1'b0;
            ack_empty_q   <= 1'b0;
            ack_fault_q   <= 1'b0;
            motor_start_q <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_MAX);
            end
`ifdef VEND_LOW_STOCK_EN
            low_stock_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            motor_sel_q   <= motor_sel_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            ack_q         <= ack_d;
            ack_ok_q      <= ack_ok_d;
            ack_empty_q   <= ack_empty_d;
            ack_fault_q   <= ack_fault_d;
            motor_start_q <= motor_start_d;
            fault_q       <= fault_d;
            busy_q        <= busy_d;
            stock_q       <= stock_d;
`ifdef VEND_LOW_STOCK_EN
            low_stock_q   <= low_stock_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign ack_ok      = ack_ok_q;
    assign ack_empty   = ack_empty_q;
    assign ack_fault   = ack_fault_q;
    assign motor_start = motor_start_q;
    assign motor_sel   = motor_sel_q;
    assign fault       = fault_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Scoreboard bench for vend_dispense_arbiter: a transaction-level model predicts each grant
// and ack; a negedge monitor pops and compares whatever the DUT presents.
module tb_vend_dispense_arbiter;

    localparam int NUM_SLOTS     = 4;
    localparam int STOCK_MAX     = 2;
    localparam int MOTOR_TIMEOUT = 8;

    localparam int K_OK    = 0;
    localparam int K_EMPTY = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int slot;
        int kind;
        int delay;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_SLOTS-1:0] req;
    logic [NUM_SLOTS-1:0] ack;
    logic                 ack_ok;
    logic                 ack_empty;
    logic                 ack_fault;
    logic                 motor_start;
    logic [1:0]           motor_sel;
    logic                 motor_done;
    logic                 restock;
    logic [1:0]           restock_slot;
    logic                 fault;
    logic                 fault_clr;
    logic                 busy;
`ifdef VEND_LOW_STOCK_EN
    logic [NUM_SLOTS-1:0] low_stock;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   start_cycle = 0;
    exp_t exp_q[$];
    int   grant_q[$];
    exp_t mon_e;
    int   mon_g;

    int   m_stock[NUM_SLOTS];
    int   m_rr;

    vend_dispense_arbiter #(
        .NUM_SLOTS    (NUM_SLOTS),
        .STOCK_MAX    (STOCK_MAX),
        .MOTOR_TIMEOUT(MOTOR_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VEND_LOW_STOCK_EN
        .low_stock   (low_stock),
`endif
        .req         (req),
        .ack         (ack),
        .ack_ok      (ack_ok),
        .ack_empty   (ack_empty),
        .ack_fault   (ack_fault),
        .motor_start (motor_start),
        .motor_sel   (motor_sel),
        .motor_done  (motor_done),
        .restock     (restock),
        .restock_slot(restock_slot),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_SLOTS; i++) m_stock[i] = STOCK_MAX;
        m_rr = 0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_ack"}, int'(ack), 0);
        checkOutput({name, "_flags"}, int'({ack_ok, ack_empty, ack_fault}), 0);
        checkOutput({name, "_motor_start"}, int'(motor_start), 0);
        checkOutput({name, "_motor_sel"}, int'(motor_sel), 0);
        checkOutput({name, "_fault_busy"}, int'({fault, busy}), 0);
    endtask

    // Monitor: every motor_start and every ack must match the head of its queue.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (!rst) begin
            if (motor_start) begin
                checkOutput("motor_start_expected", int'(grant_q.size() > 0), 1);
                if (grant_q.size() > 0) begin
                    mon_g = grant_q.pop_front();
                    checkOutput("motor_sel_at_start", int'(motor_sel), mon_g);
                    start_cycle = cycle;
                end
            end
            if (ack != '0) begin
                checkOutput("ack_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ack_vector", int'(ack), 1 << mon_e.slot);
                    checkOutput("ack_flags", int'({ack_ok, ack_empty, ack_fault}),
                                (mon_e.kind == K_OK) ? 4 : (mon_e.kind == K_EMPTY) ? 2 : 1);
                    checkOutput("motor_sel_at_ack", int'(motor_sel), mon_e.slot);
                    checkOutput("fault_at_ack", int'(fault), int'(mon_e.kind == K_FAULT));
                    checkOutput("busy_at_ack", int'(busy), int'(mon_e.kind == K_FAULT));
                    if (mon_e.kind != K_EMPTY) begin
                        checkOutput("start_to_ack_cycles", cycle - start_cycle, mon_e.delay);
                    end
                end
            end
        end
    end

    // Issue one request vector from an IDLE DUT and drive the motor side to the chosen outcome.
    task automatic applyStimulus(input logic [NUM_SLOTS-1:0] vec, input bit force_timeout,
                                 input int delay, input bit collide, output int kind);
        int   w;
        int   n;
        int   idx;
        exp_t e;
        w = -1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = (m_rr + i) % NUM_SLOTS;
            if (w < 0 && vec[idx]) w = idx;
        end
        if (m_stock[w] == 0) kind = K_EMPTY;
        else if (force_timeout) kind = K_FAULT;
        else kind = K_OK;
        if (kind == K_OK) m_stock[w] = collide ? STOCK_MAX : m_stock[w] - 1;
        m_rr = (w + 1) % NUM_SLOTS;
        e.slot  = w;
        e.kind  = kind;
        e.delay = (kind == K_FAULT) ? MOTOR_TIMEOUT : delay;
        exp_q.push_back(e);
        if (kind != K_EMPTY) grant_q.push_back(w);

        req = vec;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!motor_start && ack == '0 && n < 20);
        checkOutput("grant_latency", n, 2);

        if (kind != K_EMPTY && $urandom_range(0, 3) == 0) req = '0;
        if (kind == K_OK) begin
            repeat (delay - 1) @(negedge clk);
            motor_done = 1'b1;
            if (collide) begin
                restock      = 1'b1;
                restock_slot = 2'(w);
            end
            @(negedge clk);
            motor_done = 1'b0;
            restock    = 1'b0;
        end
        n = 0;
        while (ack == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ack_arrived", int'(ack != '0), 1);
    endtask

    task automatic idleGap(input bit do_restock, input int slot, input bit do_done);
        req = '0;
        if (do_restock) begin
            restock      = 1'b1;
            restock_slot = 2'(slot);
            m_stock[slot] = STOCK_MAX;
        end
        motor_done = do_done;
        @(negedge clk);
        restock    = 1'b0;
        motor_done = 1'b0;
        checkOutput("busy_in_gap", int'(busy), 0);
    endtask

    task automatic faultPhase(input logic [NUM_SLOTS-1:0] vec);
        req = vec;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        checkOutput("fault_held", int'(fault), 1);
        checkOutput("busy_in_fault", int'(busy), 1);
        req       = '0;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("fault_cleared", int'(fault), 0);
        checkOutput("busy_after_clear", int'(busy), 0);
    endtask

    task automatic resetDut(input string name);
        rst = 1'b1;
        req = '0;
        #1;
        checkResetOutputs(name);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        exp_q.delete();
        grant_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        int n;
        int t2_delay[6];
        t2_delay = '{1, 8, 2, 5, 8, 3};

        rst = 1'b1;
        req = '0;
        motor_done = 1'b0;
        restock = 1'b0;
        restock_slot = '0;
        fault_clr = 1'b0;
        modelReset();
        @(negedge clk);
        checkResetOutputs("reset_state");
        rst = 1'b0;

        $display("[TB] single dispense");
        applyStimulus(4'b0001, 1'b0, 3, 1'b0, kind);
        idleGap(1'b0, 0, 1'b0);
        @(negedge clk);
        resetDut("reset_between");

        $display("[TB] round-robin with held requests");
        for (int i = 0; i < 6; i++) applyStimulus(4'b1011, 1'b0, t2_delay[i], 1'b0, kind);
        idleGap(1'b0, 0, 1'b0);

        $display("[TB] empty slot and restock");
        for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0, 2, 1'b0, kind);
        idleGap(1'b1, 2, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4, 1'b0, kind);
        idleGap(1'b1, 1, 1'b0);
        idleGap(1'b1, 0, 1'b0);

        $display("[TB] motor timeout and fault");
        applyStimulus(4'b0010, 1'b1, 0, 1'b0, kind);
        faultPhase(4'b0001);
        applyStimulus(4'b0001, 1'b0, 4, 1'b0, kind);

        $display("[TB] done/restock collision and stray done");
        applyStimulus(4'b0100, 1'b0, 2, 1'b1, kind);
        idleGap(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0, 1, 1'b0, kind);
        idleGap(1'b0, 0, 1'b1);

        $display("[TB] reset during WAIT");
        grant_q.push_back(0);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!motor_start && n < 20);
        checkOutput("abort_grant_latency", n, 2);
        resetDut("reset_mid_wait");
        repeat (3) @(negedge clk);
        applyStimulus(4'b1001, 1'b0, 2, 1'b0, kind);
        idleGap(1'b0, 0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), ($urandom_range(0, 9) == 0),
                          $urandom_range(1, MOTOR_TIMEOUT), ($urandom_range(0, 5) == 0), kind);
            if (kind == K_FAULT) begin
                faultPhase(4'($urandom_range(1, 15)));
            end else if ($urandom_range(0, 2) == 0) begin
                idleGap(1'($urandom_range(0, 1)), $urandom_range(0, NUM_SLOTS - 1),
                        1'($urandom_range(0, 1)));
            end
        end

        req = '0;
        repeat (5) @(negedge clk);
        checkOutput("ack_queue_drained", exp_q.size(), 0);
        checkOutput("grant_queue_drained", grant_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
- Shares one dispense motor between NUM_SLOTS product-slot requesters from the selection panel.
- Round-robin arbitration, per-slot stock counting, motor start/done handshake, timeout fault detection.
- Sits between the per-slot vend controllers and the motor driver. Returns one completion ack per served request.

Parameters:
NUM_SLOTS, 4, number of product slots / requesters (2..16)
STOCK_MAX, 8, items loaded into a slot on reset or restock (1..255)
MOTOR_TIMEOUT, 16, max cycles from motor_start to motor_done before fault (2..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_SLOTS  level request per slot; held until matching ack
ack  out  NUM_SLOTS  one-hot, 1-cycle completion pulse to the served slot
ack_ok  out  1  with ack: item dispensed
ack_empty  out  1  with ack: slot stock was 0, nothing dispensed
ack_fault  out  1  with ack: motor timed out
motor_start  out  1  1-cycle pulse, start motor on motor_sel
motor_sel  out  clog2(NUM_SLOTS)  slot index for motor; stable from motor_start until ack
motor_done  in  1  1-cycle pulse from motor driver, item delivered
restock  in  1  1-cycle pulse: load STOCK_MAX into slot restock_slot
restock_slot  in  clog2(NUM_SLOTS)  slot to restock
fault  out  1  sticky motor fault; arbitration halted while high
fault_clr  in  1  clears fault, returns to IDLE
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state IDLE. ack, ack_ok, ack_empty, ack_fault, motor_start, fault, busy = 0. motor_sel = 0, rr_ptr = 0. Every stock counter = STOCK_MAX, timer = 0.
- All outputs are registered.
- States: IDLE, GRANT, WAIT, FAULT.
- IDLE:
  - If req != 0, pick the first asserted req at index >= rr_ptr, wrapping modulo NUM_SLOTS.
  - Latch the winner into motor_sel; go to GRANT.
  - Arbitration uses req sampled at that edge only.
- GRANT (1 cycle):
  - If stock[sel] == 0: pulse ack[sel] with ack_empty=1; rr_ptr = sel+1 mod N; go to IDLE.
  - Otherwise: pulse motor_start; clear timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - motor_done sampled high: stock[sel] -= 1; pulse ack[sel] with ack_ok=1; rr_ptr = sel+1 mod N; go to IDLE.
  - If timer reaches MOTOR_TIMEOUT without motor_done: pulse ack[sel] with ack_fault=1; set fault=1; rr_ptr = sel+1 mod N; go to FAULT. Stock is unchanged.
  - motor_done on the same edge the timeout expires counts as success.
- FAULT: hold until fault_clr, then fault=0 and go to IDLE. req is ignored while in FAULT.
- Latency:
  - req high at edge T0 in IDLE -> GRANT at T1 -> motor_start high during cycle T2.
  - Empty slot: ack during cycle T2, no motor_start.
  - After any ack, the next arbitration is at the following edge (minimum 1 IDLE cycle).
- ack_ok, ack_empty and ack_fault are mutually exclusive, and each is high only together with ack.
- motor_done outside WAIT is ignored.
- req dropped mid-operation: the transaction still completes and acks.
- req still high after its ack: it is re-arbitrated normally; round-robin prevents starvation.
- restock:
  - Accepted in any state.
  - Restock of slot sel on the same edge as motor_done: restock wins, stock = STOCK_MAX.
  - restock_slot >= NUM_SLOTS is ignored.
- Stock counters saturate at 0 and never wrap. Width is clog2(STOCK_MAX+1).
- Reset mid-operation aborts the transaction: no ack, motor_start deasserts at once.

Optional Feature:
- Macro: VEND_LOW_STOCK_EN.
- Defined: adds output low_stock [NUM_SLOTS]. Bit i is a registered flag, high when stock[i] <= 1, updated the cycle after any stock change, and 0 at reset (stock = STOCK_MAX > 1).
- Not defined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
(All with NUM_SLOTS=4, STOCK_MAX=2, MOTOR_TIMEOUT=8.)
1. Single dispense: req=0001; driver returns motor_done 3 cycles after motor_start -> motor_sel=0, one motor_start pulse, ack=0001 with ack_ok, stock[0]=1.
2. Round-robin: req=1011 held, every request served -> grant order 0,1,3,0,1,3. No slot is granted twice before every other requester is served.
3. Empty: three dispenses on slot 2 -> third ack=0100 with ack_empty, no motor_start. Then restock slot 2, request again -> ack_ok.
4. Timeout: req=0010, motor_done never arrives -> ack=0010 with ack_fault 8 cycles after motor_start, fault=1. req=0001 ignored until fault_clr, then served.
5. Collision: motor_done and restock of slot sel on the same edge -> stock[sel]=2, ack_ok. motor_done pulsed in IDLE -> no effect.
6. Reset mid-WAIT: assert rst -> no ack, all outputs 0, stocks=2, rr_ptr=0. First request after reset arbitrates from slot 0.
